// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) decode stage: decodes one instruction into a registered control bundle
// for execute, and holds the front end while a multi-cycle divide occupies execute.
module decode_ctrl_stage #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        valid_o,
    output logic        reg_write_o,
    output logic [1:0]  result_src_o,
    output logic        mem_write_o,
    output logic        jump_o,
    output logic        branch_o,
    output logic [4:0]  alu_ctrl_o,
    output logic        alu_src_o,
    output logic        alu_src_a_o,
    output logic [2:0]  imm_src_o,
    output logic [1:0]  store_src_o,
    output logic [2:0]  branch_type_o,
    output logic [2:0]  load_part_o,
    output logic        sum_src_o,
    output logic        muldiv_o,
    output logic        illegal_o,
    output logic        busy_o
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_SLT   = 5'b00101;
    localparam logic [4:0] ALU_SLL   = 5'b00110;
    localparam logic [4:0] ALU_SRL   = 5'b00111;
    localparam logic [4:0] ALU_XOR   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_SRA   = 5'b01010;
    localparam logic [4:0] ALU_LUI   = 5'b01011;
    localparam logic [4:0] ALU_AUIPC = 5'b01100;

    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [4:0] alu_ctrl;
        logic       alu_src;
        logic       alu_src_a;
        logic [2:0] imm_src;
        logic [1:0] store_src;
        logic [2:0] branch_type;
        logic [2:0] load_part;
        logic       sum_src;
        logic       muldiv;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, DIV_BUSY} state_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register and immediate fields are consumed by the register file, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

    ctrl_t dec;
    logic  dec_bad;
    logic  dec_is_div;

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        dec        = '0;
        dec_bad    = 1'b0;
        dec_is_div = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: dec.alu_ctrl = ALU_ADD;
                        3'b001: dec.alu_ctrl = ALU_SLL;
                        3'b010: dec.alu_ctrl = ALU_SLT;
                        3'b011: dec.alu_ctrl = ALU_SLTU;
                        3'b100: dec.alu_ctrl = ALU_XOR;
                        3'b101: dec.alu_ctrl = ALU_SRL;
                        3'b110: dec.alu_ctrl = ALU_OR;
                        3'b111: dec.alu_ctrl = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.alu_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.alu_ctrl = ALU_SRA;
                end else if (ENABLE_M && funct7 == F7_MUL) begin
                    // MDU codes are 10 followed by funct3; funct3[2] selects the divides.
                    dec.alu_ctrl = {2'b10, funct3};
                    dec.muldiv   = 1'b1;
                    dec_is_div   = funct3[2];
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_I;
                case (funct3)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SLL;
                        dec_bad      = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        dec.alu_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_bad      = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
                dec.imm_src    = IMM_I;
                dec.load_part  = funct3;
                dec_bad        = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_S;
                case (funct3)
                    3'b000:  dec.store_src = 2'b10;
                    3'b001:  dec.store_src = 2'b01;
                    3'b010:  dec.store_src = 2'b00;
                    default: dec_bad       = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.imm_src     = IMM_B;
                dec.branch_type = funct3;
                case (funct3)
                    3'b000, 3'b001: dec.alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: dec.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: dec.alu_ctrl = ALU_SLTU;
                    default:        dec_bad      = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                dec.imm_src    = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                dec.alu_src    = 1'b1;
                dec.imm_src    = IMM_I;
                dec.sum_src    = 1'b1;
                dec_bad        = (funct3 != 3'b000);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_ctrl  = ALU_LUI;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_ctrl  = ALU_AUIPC;
            end
            default: dec_bad = 1'b1;
        endcase
        if (dec_bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_is_div  = 1'b0;
        end
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    ctrl_t              bundle_q, bundle_d;

    assign ready_o = !stall_i && (state_q == IDLE);
    assign busy_o  = (state_q == DIV_BUSY);

    // Priority: flush, then stall, then divide bubble, then capture or bubble.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush_i) begin
            valid_d = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!stall_i) begin
            if (state_q == DIV_BUSY) begin
                valid_d = 1'b0;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (valid_i) begin
                valid_d  = 1'b1;
                bundle_d = dec;
                if (dec_is_div && DIV_CYCLES > 1) begin
                    state_d = DIV_BUSY;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign valid_o       = valid_q;
    assign reg_write_o   = bundle_q.reg_write;
    assign result_src_o  = bundle_q.result_src;
    assign mem_write_o   = bundle_q.mem_write;
    assign jump_o        = bundle_q.jump;
    assign branch_o      = bundle_q.branch;
    assign alu_ctrl_o    = bundle_q.alu_ctrl;
    assign alu_src_o     = bundle_q.alu_src;
    assign alu_src_a_o   = bundle_q.alu_src_a;
    assign imm_src_o     = bundle_q.imm_src;
    assign store_src_o   = bundle_q.store_src;
    assign branch_type_o = bundle_q.branch_type;
    assign load_part_o   = bundle_q.load_part;
    assign sum_src_o     = bundle_q.sum_src;
    assign muldiv_o      = bundle_q.muldiv;
    assign illegal_o     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: two instances (M on with 4-cycle divide, M off
// with 1-cycle divide) share randomized stimulus and are checked against a table of legal encodings.
module tb_decode_ctrl_stage;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [4:0] alu_ctrl;
        logic       alu_src;
        logic       alu_src_a;
        logic [2:0] imm_src;
        logic [1:0] store_src;
        logic [2:0] branch_type;
        logic [2:0] load_part;
        logic       sum_src;
        logic       muldiv;
        logic       illegal;
    } bundle_t;

    typedef struct packed {
        logic [31:0] fixed;
        logic [31:0] mask;
        logic        is_m;
        logic        is_div;
        bundle_t     exp;
    } entry_t;

    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23;
    localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;
    localparam logic [31:0] M_R = 32'hFE00_707F, M_F3 = 32'h0000_707F, M_OP = 32'h0000_007F;

    localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b00001, A_AND = 5'b00010, A_OR = 5'b00011;
    localparam logic [4:0] A_SLT = 5'b00101, A_SLL = 5'b00110, A_SRL = 5'b00111, A_XOR = 5'b01000;
    localparam logic [4:0] A_SLTU = 5'b01001, A_SRA = 5'b01010, A_LUI = 5'b01011, A_AUIPC = 5'b01100;
    localparam logic [2:0] I_I = 3'b001, I_S = 3'b010, I_B = 3'b011, I_U = 3'b100, I_J = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        valid_i, stall_i, flush_i;

    int checks = 0;
    int errors = 0;
    entry_t tbl[$];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                                   input logic br, input logic [4:0] alu, input logic asrc,
                                   input logic asrca, input logic [2:0] imm, input logic [1:0] ss,
                                   input logic [2:0] bt, input logic [2:0] lp, input logic sum,
                                   input logic md);
        return {rw, rs, mw, j, br, alu, asrc, asrca, imm, ss, bt, lp, sum, md, 1'b0};
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 10'b0, f3, 5'b0, op};
    endfunction

    task automatic add(input logic [31:0] fixed, input logic [31:0] mask, input logic is_m,
                       input logic is_div, input bundle_t exp);
        entry_t e;
        e.fixed  = fixed;
        e.mask   = mask;
        e.is_m   = is_m;
        e.is_div = is_div;
        e.exp    = exp;
        tbl.push_back(e);
    endtask

    task automatic rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] alu,
                         input logic is_m, input logic is_div);
        add(enc(f7, f3, OP_R), M_R, is_m, is_div, mk(1, 2'b00, 0, 0, 0, alu, 0, 0, 3'b000, 2'b00, 3'b000, 3'b000, 0, is_m));
    endtask

    task automatic itype(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] mask, input logic [4:0] alu);
        add(enc(f7, f3, OP_I), mask, 0, 0, mk(1, 2'b00, 0, 0, 0, alu, 1, 0, I_I, 2'b00, 3'b000, 3'b000, 0, 0));
    endtask

    // Every legal RV32IM encoding and the bundle it must produce.
    task automatic build_table();
        rtype(7'h00, 3'd0, A_ADD, 0, 0);   rtype(7'h00, 3'd1, A_SLL, 0, 0);
        rtype(7'h00, 3'd2, A_SLT, 0, 0);   rtype(7'h00, 3'd3, A_SLTU, 0, 0);
        rtype(7'h00, 3'd4, A_XOR, 0, 0);   rtype(7'h00, 3'd5, A_SRL, 0, 0);
        rtype(7'h00, 3'd6, A_OR, 0, 0);    rtype(7'h00, 3'd7, A_AND, 0, 0);
        rtype(7'h20, 3'd0, A_SUB, 0, 0);   rtype(7'h20, 3'd5, A_SRA, 0, 0);
        rtype(7'h01, 3'd0, 5'b10000, 1, 0); rtype(7'h01, 3'd1, 5'b10001, 1, 0);
        rtype(7'h01, 3'd2, 5'b10010, 1, 0); rtype(7'h01, 3'd3, 5'b10011, 1, 0);
        rtype(7'h01, 3'd4, 5'b10100, 1, 1); rtype(7'h01, 3'd5, 5'b10101, 1, 1);
        rtype(7'h01, 3'd6, 5'b10110, 1, 1); rtype(7'h01, 3'd7, 5'b10111, 1, 1);
        itype(7'h00, 3'd0, M_F3, A_ADD);   itype(7'h00, 3'd2, M_F3, A_SLT);
        itype(7'h00, 3'd3, M_F3, A_SLTU);  itype(7'h00, 3'd4, M_F3, A_XOR);
        itype(7'h00, 3'd6, M_F3, A_OR);    itype(7'h00, 3'd7, M_F3, A_AND);
        itype(7'h00, 3'd1, M_R, A_SLL);    itype(7'h00, 3'd5, M_R, A_SRL);
        itype(7'h20, 3'd5, M_R, A_SRA);
        foreach (tbl[i]) begin end
        for (int f = 0; f < 8; f++) begin
            if (f != 3 && f != 6 && f != 7)
                add(enc(7'h00, 3'(f), OP_LD), M_F3, 0, 0,
                    mk(1, 2'b01, 0, 0, 0, A_ADD, 1, 0, I_I, 2'b00, 3'b000, 3'(f), 0, 0));
        end
        add(enc(7'h00, 3'd0, OP_ST), M_F3, 0, 0, mk(0, 2'b00, 1, 0, 0, A_ADD, 1, 0, I_S, 2'b10, 3'b000, 3'b000, 0, 0));
        add(enc(7'h00, 3'd1, OP_ST), M_F3, 0, 0, mk(0, 2'b00, 1, 0, 0, A_ADD, 1, 0, I_S, 2'b01, 3'b000, 3'b000, 0, 0));
        add(enc(7'h00, 3'd2, OP_ST), M_F3, 0, 0, mk(0, 2'b00, 1, 0, 0, A_ADD, 1, 0, I_S, 2'b00, 3'b000, 3'b000, 0, 0));
        add(enc(7'h00, 3'd0, OP_BR), M_F3, 0, 0, mk(0, 2'b00, 0, 0, 1, A_SUB, 0, 0, I_B, 2'b00, 3'd0, 3'b000, 0, 0));
        add(enc(7'h00, 3'd1, OP_BR), M_F3, 0, 0, mk(0, 2'b00, 0, 0, 1, A_SUB, 0, 0, I_B, 2'b00, 3'd1, 3'b000, 0, 0));
        add(enc(7'h00, 3'd4, OP_BR), M_F3, 0, 0, mk(0, 2'b00, 0, 0, 1, A_SLT, 0, 0, I_B, 2'b00, 3'd4, 3'b000, 0, 0));
        add(enc(7'h00, 3'd5, OP_BR), M_F3, 0, 0, mk(0, 2'b00, 0, 0, 1, A_SLT, 0, 0, I_B, 2'b00, 3'd5, 3'b000, 0, 0));
        add(enc(7'h00, 3'd6, OP_BR), M_F3, 0, 0, mk(0, 2'b00, 0, 0, 1, A_SLTU, 0, 0, I_B, 2'b00, 3'd6, 3'b000, 0, 0));
        add(enc(7'h00, 3'd7, OP_BR), M_F3, 0, 0, mk(0, 2'b00, 0, 0, 1, A_SLTU, 0, 0, I_B, 2'b00, 3'd7, 3'b000, 0, 0));
        add(enc(7'h00, 3'd0, OP_JAL), M_OP, 0, 0, mk(1, 2'b10, 0, 1, 0, A_ADD, 0, 0, I_J, 2'b00, 3'b000, 3'b000, 0, 0));
        add(enc(7'h00, 3'd0, OP_JALR), M_F3, 0, 0, mk(1, 2'b10, 0, 1, 0, A_ADD, 1, 0, I_I, 2'b00, 3'b000, 3'b000, 1, 0));
        add(enc(7'h00, 3'd0, OP_LUI), M_OP, 0, 0, mk(1, 2'b00, 0, 0, 0, A_LUI, 1, 0, I_U, 2'b00, 3'b000, 3'b000, 0, 0));
        add(enc(7'h00, 3'd0, OP_AUIPC), M_OP, 0, 0, mk(1, 2'b00, 0, 0, 0, A_AUIPC, 1, 1, I_U, 2'b00, 3'b000, 3'b000, 0, 0));
    endtask

    // Reference model: anything not matching a legal table entry is an illegal bundle.
    function automatic bundle_t model(input logic [31:0] ins, input bit en_m);
        bundle_t e = '0;
        e.illegal = 1'b1;
        foreach (tbl[i])
            if ((ins & tbl[i].mask) == tbl[i].fixed && (en_m || !tbl[i].is_m)) e = tbl[i].exp;
        return e;
    endfunction

    function automatic bit model_div(input logic [31:0] ins, input bit en_m);
        bit d = 1'b0;
        foreach (tbl[i])
            if ((ins & tbl[i].mask) == tbl[i].fixed && (en_m || !tbl[i].is_m)) d = tbl[i].is_div;
        return d;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit EN_M = (g == 0);
        localparam int DC   = (g == 0) ? 4 : 1;

        logic ready_o, valid_o, reg_write_o, mem_write_o, jump_o, branch_o;
        logic alu_src_o, alu_src_a_o, sum_src_o, muldiv_o, illegal_o, busy_o;
        logic [1:0] result_src_o, store_src_o;
        logic [2:0] imm_src_o, branch_type_o, load_part_o;
        logic [4:0] alu_ctrl_o;
        bundle_t got;
        bundle_t exp_q[$];
        bundle_t last_exp;
        int      busy_left;
        logic    exp_valid;
        logic    fresh;

        decode_ctrl_stage #(.ENABLE_M(EN_M), .DIV_CYCLES(DC)) dut (
            .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .valid_i(valid_i), .ready_o(ready_o),
            .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .reg_write_o(reg_write_o),
            .result_src_o(result_src_o), .mem_write_o(mem_write_o), .jump_o(jump_o),
            .branch_o(branch_o), .alu_ctrl_o(alu_ctrl_o), .alu_src_o(alu_src_o),
            .alu_src_a_o(alu_src_a_o), .imm_src_o(imm_src_o), .store_src_o(store_src_o),
            .branch_type_o(branch_type_o), .load_part_o(load_part_o), .sum_src_o(sum_src_o),
            .muldiv_o(muldiv_o), .illegal_o(illegal_o), .busy_o(busy_o)
        );

        assign got = {reg_write_o, result_src_o, mem_write_o, jump_o, branch_o, alu_ctrl_o,
                      alu_src_o, alu_src_a_o, imm_src_o, store_src_o, branch_type_o,
                      load_part_o, sum_src_o, muldiv_o, illegal_o};

        // Issue side: predict acceptance, occupancy and valid, and queue expected bundles.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_left <= 0;
                exp_valid <= 1'b0;
                fresh     <= 1'b0;
                exp_q.delete();
            end else begin
                fresh <= !flush_i && !stall_i;
                if (flush_i) begin
                    exp_valid <= 1'b0;
                    busy_left <= 0;
                end else if (!stall_i) begin
                    if (busy_left > 0) begin
                        exp_valid <= 1'b0;
                        busy_left <= busy_left - 1;
                    end else if (valid_i) begin
                        exp_q.push_back(model(instr_i, EN_M));
                        exp_valid <= 1'b1;
                        busy_left <= (model_div(instr_i, EN_M) && DC > 1) ? DC - 1 : 0;
                    end else begin
                        exp_valid <= 1'b0;
                    end
                end
            end
        end

        // Monitor: compare whatever the DUT presents against the scoreboard.
        always @(negedge clk) begin
            if (!rst_n) begin
                check($sformatf("reset_bundle[%0d]", g), 32'(got), 32'd0);
                check($sformatf("reset_valid[%0d]", g), 32'(valid_o), 32'd0);
                check($sformatf("reset_busy[%0d]", g), 32'(busy_o), 32'd0);
            end else begin
                check($sformatf("ready[%0d]", g), 32'(ready_o), 32'(!stall_i && busy_left == 0));
                check($sformatf("busy[%0d]", g), 32'(busy_o), 32'(busy_left > 0));
                check($sformatf("valid[%0d]", g), 32'(valid_o), 32'(exp_valid));
                if (valid_o === 1'b1) begin
                    if (!fresh) begin
                        check($sformatf("hold_bundle[%0d]", g), 32'(got), 32'(last_exp));
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bundle[%0d]: got %h expected none", g, got);
                    end else begin
                        check($sformatf("bundle[%0d] instr", g), 32'(got), 32'(exp_q[0]));
                        last_exp <= exp_q.pop_front();
                    end
                end
            end
        end
    end

    task automatic cycle(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        instr_i = ins;
        valid_i = v;
        stall_i = st;
        flush_i = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        int          r   = $urandom_range(0, 9);
        entry_t      e   = tbl[$urandom_range(0, tbl.size() - 1)];
        logic [31:0] ins = ($urandom & ~e.mask) | e.fixed;
        int          p   = $urandom_range(0, 16);
        int          pos = (p < 7) ? p : ((p < 10) ? p + 5 : p + 15);
        if (r >= 8) ins = $urandom;
        else if (r >= 6) ins = ins ^ (32'd1 << pos);
        return ins;
    endfunction

    localparam logic [31:0] ADD_I  = 32'h002081B3;
    localparam logic [31:0] SW_I   = 32'h0020A223;
    localparam logic [31:0] LBU_I  = 32'h0000C183;
    localparam logic [31:0] DIV_I  = 32'h0220C1B3;
    localparam logic [31:0] MUL_I  = 32'h022081B3;
    localparam logic [31:0] XOR_I  = 32'h007342B3;
    localparam logic [31:0] SRAI_B = 32'h2010D093;

    initial begin
        build_table();
        rst_n = 1'b0;
        cycle(32'd0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        cycle(ADD_I, 1, 0, 0);
        cycle(SW_I, 1, 0, 0);
        cycle(LBU_I, 1, 0, 0);
        cycle(32'd0, 0, 0, 0);
        cycle(DIV_I, 1, 0, 0);
        repeat (5) cycle(ADD_I, 1, 0, 0);
        cycle(DIV_I, 1, 0, 0);
        cycle(32'd0, 0, 0, 0);
        cycle(32'd0, 0, 0, 1);
        cycle(ADD_I, 1, 0, 0);
        cycle(32'd0, 0, 0, 0);
        cycle(XOR_I, 1, 1, 0);
        cycle(XOR_I, 1, 1, 0);
        cycle(XOR_I, 1, 0, 0);
        cycle(ADD_I, 1, 0, 1);
        cycle(32'd0, 1, 0, 0);
        cycle(SRAI_B, 1, 0, 0);
        cycle(MUL_I, 1, 0, 0);
        cycle(32'd0, 0, 0, 0);

        repeat (3000) begin
            logic v, st, fl;
            v  = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 99) < 15);
            fl = ($urandom_range(0, 99) < 5);
            cycle(gen_instr(), v, st, fl);
        end

        repeat (8) cycle(32'd0, 0, 0, 0);
        check("drain[0]", 32'(g_dut[0].exp_q.size()), 32'd0);
        check("drain[1]", 32'(g_dut[1].exp_q.size()), 32'd0);

        // Reset in the middle of a divide must clear everything at once.
        cycle(DIV_I, 1, 0, 0);
        cycle(32'd0, 0, 0, 0);
        #3 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(ADD_I, 1, 0, 0);
        repeat (3) cycle(32'd0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
